// File: rtl/ascii_uart_tx.sv
// rtl/ascii_uart_tx.sv - 8N1 UART transmitter fed by a small burst-absorbing byte FIFO
module ascii_uart_tx #(
  parameter int DIV   = 4,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_level,
  output logic       overflow
);
  localparam int BW = $clog2(DIV);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(DIV - 1);
  localparam logic [3:0]    LEVEL_FULL = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop, baud_end, have_data;

  // Full is judged on the pre-edge level, so a pop on the same edge never rescues a write.
  assign full      = (fifo_level == LEVEL_FULL);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign have_data = (fifo_level != 4'd0);
  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 4'd0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 4'd1;
        2'b01:   fifo_level <= fifo_level - 4'd1;
        default: fifo_level <= fifo_level;
      endcase
      if (in_valid && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_n       = 1'b1;
        baud_cnt_n = '0;
        if (have_data) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          bit_cnt_n  = 3'd0;
          tx_n       = shift[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          shift_n    = {1'b0, shift[7:1]};
          bit_cnt_n  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          // Chain straight into the next start bit so bursts leave no idle gap.
          if (have_data) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb/tb_ascii_uart_tx.sv - randomized self-checking bench for ascii_uart_tx against a frame-schedule model
module tb_ascii_uart_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       in_ready, tx, busy, overflow;
  logic [3:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  ascii_uart_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clr_ovf(clr_ovf), .tx(tx), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model: FIFO as a queue; a frame occupies FRAME edges starting at its pop edge.
  int         e = 0;
  int         m_frame_end = 0;
  logic [7:0] m_cur = 8'd0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];

  // Line receiver: samples each bit slot in its middle, independent of the model.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = 8'd0;
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_slot = 0;
  int         rx_err = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt % DIV == DIV / 2) begin
        rx_slot = rx_cnt / DIV;
        if (rx_slot == 0) begin
          if (tx !== 1'b0) rx_err++;
        end else if (rx_slot <= 8) begin
          rx_sh[rx_slot-1] = tx;
        end else begin
          if (tx !== 1'b1) rx_err++;
          rx_q.push_back(rx_sh);
          rx_active = 1'b0;
        end
      end
    end
  end

  function automatic logic exp_tx();
    int slot;
    if (e >= m_frame_end) return 1'b1;
    slot = (e - (m_frame_end - FRAME)) / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (e < m_frame_end) ? 1'b1 : 1'b0;
  endfunction

  function automatic bit rx_matches();
    if (rx_q.size() != exp_q.size()) return 1'b0;
    foreach (rx_q[i]) if (rx_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    rx_q.delete();
    m_frame_end = e;
    m_ovf = 1'b0;
    rx_err = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic c);
    bit was_full;
    e++;
    was_full = (m_q.size() >= DEPTH);
    if (m_q.size() > 0 && e >= m_frame_end) begin
      m_cur = m_q.pop_front();
      exp_q.push_back(m_cur);
      m_frame_end = e + FRAME;
    end
    if (v && !was_full) m_q.push_back(d);
    if (v && was_full) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr_ovf  = c;
    @(posedge clk);
    #1;
    model_edge(v, d, c);
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_tests++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_tests++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    logic       want_tx;
    int         busy_cnt;
    b = 8'h54;
    busy_cnt = 0;
    drive(1'b1, b, 1'b0);
    n_tests++;
    if (fifo_level !== 4'd1 || busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_edge0: level=%0d busy=%b tx=%b want 1 0 1", fifo_level, busy, tx);
    end
    for (int i = 1; i <= 44; i++) begin
      drive(1'b0, 8'd0, 1'b0);
      want_tx = (i <= 4) ? 1'b0 : (i <= 36) ? b[(i-5)/4] : 1'b1;
      if (busy === 1'b1) busy_cnt++;
      n_tests++;
      if (tx !== want_tx || busy !== (i <= 40)) begin
        n_fail++;
        $display("FAIL single_cycle %0d: tx=%b busy=%b want tx=%b busy=%b", i, tx, busy, want_tx, (i <= 40));
      end
    end
    n_tests++; if (busy_cnt != 40) begin n_fail++; $display("FAIL single_busy_len: got %0d want 40", busy_cnt); end
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== b || rx_err != 0) begin
      n_fail++;
      $display("FAIL single_rx: frames=%0d first=%h errs=%0d want 1 54 0", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rx_err);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_burst_overflow();
    logic [7:0] b [10];
    int busy_cnt;
    busy_cnt = 0;
    foreach (b[k]) b[k] = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, b[k], 1'b0);
      if (busy === 1'b1) busy_cnt++;
      n_tests++;
      if (tx !== exp_tx() || busy !== exp_busy() || fifo_level !== 4'(m_q.size()) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL burst_fill k=%0d: tx=%b busy=%b level=%0d ovf=%b want %b %b %0d %b", k, tx, busy, fifo_level, overflow, exp_tx(), exp_busy(), m_q.size(), m_ovf);
      end
      if (k == 8) begin
        n_tests++;
        if (fifo_level !== 4'd8 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL burst_full: level=%0d in_ready=%b want 8 0", fifo_level, in_ready);
        end
      end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL burst_ovf: got %b want 1", overflow); end
    for (int i = 0; i < 1000 && (m_q.size() > 0 || e < m_frame_end); i++) begin
      drive(1'b0, 8'd0, 1'b0);
      if (busy === 1'b1) busy_cnt++;
      n_tests++;
      if (tx !== exp_tx() || busy !== exp_busy() || fifo_level !== 4'(m_q.size())) begin
        n_fail++;
        $display("FAIL burst_drain e=%0d: tx=%b busy=%b level=%0d want %b %b %0d", e, tx, busy, fifo_level, exp_tx(), exp_busy(), m_q.size());
      end
    end
    n_tests++; if (busy_cnt != 360) begin n_fail++; $display("FAIL burst_busy_len: got %0d want 360", busy_cnt); end
    n_tests++;
    if (rx_q.size() != 9 || !rx_matches() || rx_err != 0) begin
      n_fail++;
      $display("FAIL burst_rx: frames=%0d match=%0d errs=%0d want 9 1 0", rx_q.size(), rx_matches(), rx_err);
    end
    for (int k = 0; k < 9 && k < rx_q.size(); k++) begin
      n_tests++;
      if (rx_q[k] !== b[k]) begin n_fail++; $display("FAIL burst_byte %0d: got %h want %h", k, rx_q[k], b[k]); end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow_clear();
    drive(1'b0, 8'd0, 1'b1);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", overflow); end
    for (int k = 0; k < 10; k++) drive(1'b1, 8'($urandom), (k == 9) ? 1'b1 : 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || m_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_drop: got %b want 1", overflow);
    end
    for (int i = 0; i < 1000 && (m_q.size() > 0 || e < m_frame_end); i++) begin
      drive(1'b0, 8'd0, 1'b0);
      n_tests++;
      if (tx !== exp_tx() || busy !== exp_busy() || fifo_level !== 4'(m_q.size()) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL clr_drain e=%0d: tx=%b busy=%b level=%0d ovf=%b want %b %b %0d %b", e, tx, busy, fifo_level, overflow, exp_tx(), exp_busy(), m_q.size(), m_ovf);
      end
    end
    drive(1'b0, 8'd0, 1'b1);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf_again: got %b want 0", overflow); end
    n_tests++;
    if (!rx_matches() || rx_err != 0) begin
      n_fail++;
      $display("FAIL clr_rx: frames=%0d want %0d errs=%0d", rx_q.size(), exp_q.size(), rx_err);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_pointer_wrap();
    string s;
    logic  v, c;
    s = "Tajumulco ";
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < s.len(); k++) begin
        int gap;
        gap = $urandom_range(3, 45);
        for (int g = 0; g <= gap; g++) begin
          drive((g == 0) ? 1'b1 : 1'b0, s[k], 1'b0);
          n_tests++;
          if (tx !== exp_tx() || busy !== exp_busy() || fifo_level !== 4'(m_q.size()) || fifo_level > 4'd8) begin
            n_fail++;
            $display("FAIL wrap_str e=%0d: tx=%b busy=%b level=%0d want %b %b %0d", e, tx, busy, fifo_level, exp_tx(), exp_busy(), m_q.size());
          end
        end
      end
    end
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 15) == 0);
      drive(v, 8'($urandom), c);
      n_tests++;
      if (tx !== exp_tx() || busy !== exp_busy() || fifo_level !== 4'(m_q.size()) || fifo_level > 4'd8 ||
          overflow !== m_ovf || in_ready !== (m_q.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL wrap_rand e=%0d: tx=%b busy=%b level=%0d ovf=%b rdy=%b want %b %b %0d %b %b", e, tx, busy, fifo_level, overflow, in_ready, exp_tx(), exp_busy(), m_q.size(), m_ovf, (m_q.size() < DEPTH));
      end
    end
    for (int i = 0; i < 1000 && (m_q.size() > 0 || e < m_frame_end); i++) begin
      drive(1'b0, 8'd0, 1'b0);
      n_tests++;
      if (tx !== exp_tx() || busy !== exp_busy() || fifo_level !== 4'(m_q.size())) begin
        n_fail++;
        $display("FAIL wrap_drain e=%0d: tx=%b busy=%b level=%0d want %b %b %0d", e, tx, busy, fifo_level, exp_tx(), exp_busy(), m_q.size());
      end
    end
    n_tests++;
    if (!rx_matches() || rx_err != 0) begin
      n_fail++;
      $display("FAIL wrap_rx: frames=%0d want %0d errs=%0d", rx_q.size(), exp_q.size(), rx_err);
    end
    for (int k = 0; k < s.len() && k < rx_q.size(); k++) begin
      n_tests++;
      if (rx_q[k] !== s[k]) begin n_fail++; $display("FAIL wrap_char %0d: got %h want %h", k, rx_q[k], s[k]); end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 8'h54, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < FRAME && (e - (m_frame_end - FRAME)) < 17; i++) drive(1'b0, 8'd0, 1'b0);
    n_tests++;
    if (tx !== 1'b0 || busy !== 1'b1 || fifo_level !== 4'(m_q.size())) begin
      n_fail++;
      $display("FAIL mid_pre: tx=%b busy=%b level=%0d want 0 1 %0d", tx, busy, fifo_level, m_q.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: tx=%b busy=%b level=%0d ovf=%b want 1 0 0 0", tx, busy, fifo_level, overflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 8'h41, 1'b0);
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 8'd0, 1'b0);
      n_tests++;
      if (tx !== exp_tx() || busy !== exp_busy() || fifo_level !== 4'(m_q.size())) begin
        n_fail++;
        $display("FAIL mid_after e=%0d: tx=%b busy=%b level=%0d want %b %b %0d", e, tx, busy, fifo_level, exp_tx(), exp_busy(), m_q.size());
      end
    end
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h41 || rx_err != 0 || fifo_level !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_rx: frames=%0d first=%h errs=%0d level=%0d want 1 41 0 0", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rx_err, fifo_level);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_burst_overflow();
    test_overflow_clear();
    test_pointer_wrap();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
